median3_stream: RTL and testbench

- Streaming 3-tap 1D median filter. It is the read/consume side of the sample delay line: it takes a framed sample stream and emits one median per input sample.
- Holds the two previous samples in a register window and replicates the edge sample at both frame boundaries.
- Uses a valid/ready handshake on both sides, so it can sit between the sample source and the downstream consumer with full throughput.

---
 rtl/median3_stream.sv | 136 +++++++++++++
 tb/tb_median3_stream.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/median3_stream.sv
// median3_stream: streaming 3-tap 1D median filter with edge replication.
// Consumes a framed sample stream over valid/ready and produces one median
// per input sample. The first and last samples of a frame see their own
// value replicated into the missing window slot.
// Optional build macro: MEDIAN3_SIGNED_EN (treat samples as two's-complement).
module median3_stream #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_prev;
   logic [DATA_W-1:0] r_cur;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;

   logic              w_slot_free;
   logic              w_in_ready;
   logic              w_in_xfer;
   logic              w_load_run;
   logic              w_load_flush;
   logic [DATA_W-1:0] w_median;

   // Ordering used by every comparison in the median network.
   function automatic logic less_than(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
`ifdef MEDIAN3_SIGNED_EN
      return ($signed(a) < $signed(b));
`else
      return (a < b);
`endif
   endfunction

   // median(a,b,c) = max(min(a,b), min(max(a,b),c))
   function automatic logic [DATA_W-1:0] median3(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] c);
      logic [DATA_W-1:0] lo;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] mid;
      lo  = less_than(a, b) ? a : b;
      hi  = less_than(a, b) ? b : a;
      mid = less_than(hi, c) ? hi : c;
      return less_than(lo, mid) ? mid : lo;
   endfunction

   assign w_slot_free  = !r_out_valid || out_ready;
   assign w_in_xfer    = in_valid && w_in_ready;
   assign w_load_run   = (r_state == ST_RUN) && w_in_xfer;
   assign w_load_flush = (r_state == ST_FLUSH) && w_slot_free;
   assign w_median     = median3(r_prev, r_cur, in_data);

   // Input acceptance depends on window state and output slot availability.
   always_comb begin
      w_in_ready = 1'b0;
      case (r_state)
         ST_EMPTY: w_in_ready = 1'b1;
         ST_RUN:   w_in_ready = w_slot_free;
         ST_FLUSH: w_in_ready = 1'b0;
         default:  w_in_ready = 1'b0;
      endcase
   end

   // Window registers and frame state sequencing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_EMPTY;
         r_prev  <= '0;
         r_cur   <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_xfer) begin
                  r_prev  <= in_data;
                  r_cur   <= in_data;
                  r_state <= in_last ? ST_FLUSH : ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_in_xfer) begin
                  r_prev  <= r_cur;
                  r_cur   <= in_data;
                  r_state <= in_last ? ST_FLUSH : ST_RUN;
               end
            end
            ST_FLUSH: begin
               if (w_slot_free) begin
                  r_state <= ST_EMPTY;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   // Single-entry output register; a new load wins over a same-cycle drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_load_run) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_median;
         r_out_last  <= 1'b0;
      end else if (w_load_flush) begin
         // median(prev,cur,cur) always reduces to cur
         r_out_valid <= 1'b1;
         r_out_data  <= r_cur;
         r_out_last  <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_median3_stream.sv
// Directed table-driven bench for median3_stream.
module tb_median3_stream;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic [7:0] ed;
      logic       el;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       in_last = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_last;

   int   checks = 0;
   int   failures = 0;
   int   zero_rdy = 0;
   logic bp_mode = 1'b0;
   logic [3:0] pat = 4'b1001;
   int   cyc = 0;

   logic [8:0] q[$];
   vec_t tv[19];

   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;

   median3_stream #(.DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] d, input logic l,
                               input logic [7:0] ed, input logic el);
      vec_t v;
      v.d = d; v.l = l; v.ed = ed; v.el = el;
      return v;
   endfunction

   // Output monitor: records transfers and checks hold stability under backpressure.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               chk("hold_valid", {31'd0, out_valid}, 32'd1);
               chk("hold_data", {24'd0, out_data}, {24'd0, prev_data});
               chk("hold_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (!in_ready) zero_rdy++;
            if (out_valid && out_ready) q.push_back({out_last, out_data});
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
         end
      end
   end

   // Backpressure pattern driver for out_ready.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) begin
            out_ready = pat[cyc];
            cyc = (cyc + 1) % 4;
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic l);
      logic done;
      done = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_vecs(input int lo, input int hi, input string name);
      int n;
      n = hi - lo + 1;
      q.delete();
      for (int i = lo; i <= hi; i++) send(tv[i].d, tv[i].l);
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int k = 0; k < 300 && q.size() < n; k++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk({name, "_count"}, q.size(), n);
      for (int j = 0; j < n; j++) begin
         if (j < q.size()) begin
            chk($sformatf("%s_data[%0d]", name, j), {24'd0, q[j][7:0]}, {24'd0, tv[lo+j].ed});
            chk($sformatf("%s_last[%0d]", name, j), {31'd0, q[j][8]}, {31'd0, tv[lo+j].el});
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      tv[0]  = mk(8'd5, 1'b0, 8'd5, 1'b0);
      tv[1]  = mk(8'd1, 1'b0, 8'd5, 1'b0);
      tv[2]  = mk(8'd9, 1'b0, 8'd3, 1'b0);
      tv[3]  = mk(8'd3, 1'b0, 8'd7, 1'b0);
      tv[4]  = mk(8'd7, 1'b1, 8'd7, 1'b1);
      tv[5]  = mk(8'h2A, 1'b1, 8'h2A, 1'b1);
      tv[6]  = mk(8'd4, 1'b0, 8'd4, 1'b0);
      tv[7]  = mk(8'd4, 1'b1, 8'd4, 1'b1);
      tv[8]  = mk(8'd2, 1'b0, 8'd2, 1'b0);
      tv[9]  = mk(8'd8, 1'b0, 8'd4, 1'b0);
      tv[10] = mk(8'd4, 1'b1, 8'd4, 1'b1);
      tv[11] = mk(8'd6, 1'b0, 8'd6, 1'b0);
      tv[12] = mk(8'd6, 1'b1, 8'd6, 1'b1);
      tv[13] = mk(8'hFF, 1'b0, 8'hFF, 1'b0);
`ifdef MEDIAN3_SIGNED_EN
      tv[14] = mk(8'h01, 1'b0, 8'hFF, 1'b0);
`else
      tv[14] = mk(8'h01, 1'b0, 8'h80, 1'b0);
`endif
      tv[15] = mk(8'h80, 1'b1, 8'h80, 1'b1);
      tv[16] = mk(8'd1, 1'b0, 8'd1, 1'b0);
      tv[17] = mk(8'd2, 1'b0, 8'd2, 1'b0);
      tv[18] = mk(8'd3, 1'b1, 8'd3, 1'b1);

      // Reset state
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Basic frame with full throughput; exactly one FLUSH bubble
      zero_rdy = 0;
      run_vecs(0, 4, "frame1");
      chk("flush_bubble", zero_rdy, 32'd1);

      // Single-sample frame, then a two-sample frame
      run_vecs(5, 5, "single");
      run_vecs(6, 7, "pair");

      // Backpressure with out_ready pattern 1,0,0,1
      cyc = 0;
      bp_mode = 1'b1;
      run_vecs(0, 4, "bp");
      bp_mode = 1'b0;
      out_ready = 1'b1;

      // Back-to-back frames with in_valid held high
      run_vecs(8, 12, "b2b");

      // Signedness-dependent ordering
      run_vecs(13, 15, "sign");

      // Asynchronous reset mid-frame with a pending output
      out_ready = 1'b0;
      send(8'd10, 1'b0);
      send(8'd20, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      chk("pre_rst_data", {24'd0, out_data}, 32'd10);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_data", {24'd0, out_data}, 32'd0);
      chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
      repeat (3) @(negedge clk);
      out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      run_vecs(16, 18, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

endmodule
